// File: rtl/uns_acc_drv.sv
// uns_acc_drv: takes one command, clears uns_acc, drives its operand bus for N cycles,
// then captures o_data/o_carry. Define UNS_ACC_DRV_CHECK_EN to add a reference-model checker.
module uns_acc_drv #(
    parameter int DW = 3,
    parameter int AW = 6,
    parameter int NW = 4
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [1:0]    i_sel,
    input  logic [DW-1:0] i_data1,
    input  logic [DW-1:0] i_data2,
    input  logic [NW-1:0] i_n_ops,
    output logic          o_acc_rst_n,
    output logic [1:0]    o_acc_sel,
    output logic [DW-1:0] o_acc_data1,
    output logic [DW-1:0] o_acc_data2,
    input  logic [AW-1:0] i_acc_data,
    input  logic          i_acc_carry,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW-1:0] o_result,
    output logic          o_carry,
    output logic          o_mismatch
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_SETTLE,
        S_DONE
    } state_e;

    localparam logic [1:0] SEL_HOLD = 2'b11;

    state_e        state_q, state_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [1:0]    cmd_sel_q, cmd_sel_d;
    logic [DW-1:0] cmd_d1_q, cmd_d1_d;
    logic [DW-1:0] cmd_d2_q, cmd_d2_d;

    logic          acc_rst_n_q, acc_rst_n_d;
    logic [1:0]    acc_sel_q, acc_sel_d;
    logic [DW-1:0] acc_d1_q, acc_d1_d;
    logic [DW-1:0] acc_d2_q, acc_d2_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] result_q, result_d;
    logic          carry_q, carry_d;

    wire accept = (state_q == S_IDLE) && i_start;

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_sel_q   <= SEL_HOLD;
            cmd_d1_q    <= '0;
            cmd_d2_q    <= '0;
            acc_rst_n_q <= 1'b0;
            acc_sel_q   <= SEL_HOLD;
            acc_d1_q    <= '0;
            acc_d2_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_sel_q   <= cmd_sel_d;
            cmd_d1_q    <= cmd_d1_d;
            cmd_d2_q    <= cmd_d2_d;
            acc_rst_n_q <= acc_rst_n_d;
            acc_sel_q   <= acc_sel_d;
            acc_d1_q    <= acc_d1_d;
            acc_d2_q    <= acc_d2_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_sel_d = cmd_sel_q;
        cmd_d1_d  = cmd_d1_q;
        cmd_d2_d  = cmd_d2_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    cmd_sel_d = i_sel;
                    cmd_d1_d  = i_data1;
                    cmd_d2_d  = i_data2;
                    cnt_d     = i_n_ops;
                    state_d   = S_CLR;
                end
            end
            S_CLR:    state_d = (cnt_q == '0) ? S_SETTLE : S_RUN;
            S_RUN: begin
                cnt_d = cnt_q - NW'(1);
                if (cnt_q == NW'(1)) state_d = S_SETTLE;
            end
            S_SETTLE: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        acc_rst_n_d = (state_d != S_CLR);
        acc_sel_d   = SEL_HOLD;
        acc_d1_d    = '0;
        acc_d2_d    = '0;
        if (state_d == S_RUN) begin
            acc_sel_d = cmd_sel_q;
            acc_d1_d  = cmd_d1_q;
            acc_d2_d  = cmd_d2_q;
        end
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        result_d = done_d ? i_acc_data  : result_q;
        carry_d  = done_d ? i_acc_carry : carry_q;
    end

    assign o_acc_rst_n = acc_rst_n_q;
    assign o_acc_sel   = acc_sel_q;
    assign o_acc_data1 = acc_d1_q;
    assign o_acc_data2 = acc_d2_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_result    = result_q;
    assign o_carry     = carry_q;

`ifdef UNS_ACC_DRV_CHECK_EN
    logic [AW-1:0] mdl_acc_q, mdl_acc_d;
    logic          mdl_carry_q, mdl_carry_d;
    logic          mismatch_q, mismatch_d;
    logic [AW:0]   addend, sum;

    always_comb begin
        unique case (cmd_sel_q)
            2'b00:   addend = (AW+1)'(cmd_d1_q);
            2'b01:   addend = (AW+1)'(cmd_d2_q);
            2'b10:   addend = (AW+1)'(cmd_d1_q) + (AW+1)'(cmd_d2_q);
            default: addend = '0;
        endcase
        sum         = {1'b0, mdl_acc_q} + addend;
        mdl_acc_d   = mdl_acc_q;
        mdl_carry_d = mdl_carry_q;
        if (state_q == S_CLR) begin
            mdl_acc_d   = '0;
            mdl_carry_d = 1'b0;
        end else if (state_q == S_RUN) begin
            mdl_acc_d   = sum[AW-1:0];
            mdl_carry_d = mdl_carry_q | sum[AW];
        end
        mismatch_d = mismatch_q;
        if (accept) begin
            mismatch_d = 1'b0;
        end else if (state_q == S_SETTLE &&
                     (i_acc_data != mdl_acc_q || i_acc_carry != mdl_carry_q)) begin
            mismatch_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mdl_acc_q   <= '0;
            mdl_carry_q <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            mdl_acc_q   <= mdl_acc_d;
            mdl_carry_q <= mdl_carry_d;
            mismatch_q  <= mismatch_d;
        end
    end

    assign o_mismatch = mismatch_q;
`else
    wire unused_accept = accept;
    assign o_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_uns_acc_drv.sv
// Self-checking bench for uns_acc_drv: a behavioural uns_acc stub plus a command-level
// expectation model compared on every falling edge, and directed literal checks.
module tb_uns_acc_drv;
    localparam int DW = 3;
    localparam int AW = 6;
    localparam int NW = 4;
`ifdef UNS_ACC_DRV_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic          i_start;
    logic [1:0]    i_sel;
    logic [DW-1:0] i_data1, i_data2;
    logic [NW-1:0] i_n_ops;
    logic          o_acc_rst_n;
    logic [1:0]    o_acc_sel;
    logic [DW-1:0] o_acc_data1, o_acc_data2;
    logic [AW-1:0] i_acc_data;
    logic          i_acc_carry;
    logic          o_busy, o_done, o_carry, o_mismatch;
    logic [AW-1:0] o_result;

    int checks = 0;
    int errors = 0;

    uns_acc_drv #(.DW(DW), .AW(AW), .NW(NW)) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_sel      (i_sel),
        .i_data1    (i_data1),
        .i_data2    (i_data2),
        .i_n_ops    (i_n_ops),
        .o_acc_rst_n(o_acc_rst_n),
        .o_acc_sel  (o_acc_sel),
        .o_acc_data1(o_acc_data1),
        .o_acc_data2(o_acc_data2),
        .i_acc_data (i_acc_data),
        .i_acc_carry(i_acc_carry),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_result   (o_result),
        .o_carry    (o_carry),
        .o_mismatch (o_mismatch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- uns_acc stub (environment), with optional +1 read error
    logic [AW-1:0] stub_acc;
    logic          stub_carry;
    logic          inj;
    logic [AW:0]   stub_nxt;

    function automatic logic [AW:0] stub_sum(logic [AW-1:0] a, logic [1:0] s,
                                             logic [DW-1:0] x, logic [DW-1:0] y);
        case (s)
            2'b00:   return {1'b0, a} + (AW+1)'(x);
            2'b01:   return {1'b0, a} + (AW+1)'(y);
            2'b10:   return {1'b0, a} + (AW+1)'(x) + (AW+1)'(y);
            default: return {1'b0, a};
        endcase
    endfunction

    assign stub_nxt    = stub_sum(stub_acc, o_acc_sel, o_acc_data1, o_acc_data2);
    assign i_acc_data  = stub_acc + AW'(inj);
    assign i_acc_carry = stub_carry;

    always_ff @(posedge clk or negedge o_acc_rst_n) begin
        if (!o_acc_rst_n) begin
            stub_acc   <= '0;
            stub_carry <= 1'b0;
        end else begin
            stub_acc   <= stub_nxt[AW-1:0];
            stub_carry <= stub_carry | stub_nxt[AW];
        end
    end

    // ---------------- command-level expectation model
    function automatic int tot(logic [1:0] s, logic [DW-1:0] a, logic [DW-1:0] b, int n);
        case (s)
            2'b00:   return n * int'(a);
            2'b01:   return n * int'(b);
            2'b10:   return n * (int'(a) + int'(b));
            default: return 0;
        endcase
    endfunction

    int            edge_cnt = 0;
    bit            m_inflight = 1'b0;
    int            m_acc_edge = 0;
    int            m_n = 0;
    logic [1:0]    m_sel;
    logic [DW-1:0] m_d1, m_d2;
    bit            m_inj;
    logic [AW-1:0] m_res;
    logic          m_carry, m_mis;
    int            d;
    bit            e_busy, e_done;

    always @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_inflight <= 1'b0;
            m_res      <= '0;
            m_carry    <= 1'b0;
            m_mis      <= 1'b0;
        end else begin
            edge_cnt <= edge_cnt + 1;
            if (!(m_inflight && (edge_cnt - m_acc_edge) <= m_n + 2) && i_start) begin
                m_inflight <= 1'b1;
                m_acc_edge <= edge_cnt + 1;
                m_n        <= int'(i_n_ops);
                m_sel      <= i_sel;
                m_d1       <= i_data1;
                m_d2       <= i_data2;
                m_inj      <= inj;
                m_mis      <= 1'b0;
            end else if (m_inflight && (edge_cnt + 1 - m_acc_edge) == m_n + 2) begin
                m_res   <= AW'((tot(m_sel, m_d1, m_d2, m_n) % 64 + int'(m_inj)) % 64);
                m_carry <= (tot(m_sel, m_d1, m_d2, m_n) >= 64);
                if (CHK && m_inj) m_mis <= 1'b1;
            end
        end
    end

    always_comb begin
        d      = edge_cnt - m_acc_edge;
        e_busy = m_inflight && d >= 0 && d <= m_n + 2;
        e_done = m_inflight && d == m_n + 2;
    end

    always @(negedge clk) begin
        check("busy", 32'(o_busy), 32'(e_busy));
        check("done", 32'(o_done), 32'(e_done));
        check("result", 32'(o_result), 32'(m_res));
        check("carry", 32'(o_carry), 32'(m_carry));
        check("mismatch", 32'(o_mismatch), 32'(m_mis));
        if (e_busy) begin
            check("acc_rst_n", 32'(o_acc_rst_n), 32'(d != 0));
            if (d >= 1 && d <= m_n) begin
                check("acc_sel", 32'(o_acc_sel), 32'(m_sel));
                check("acc_data1", 32'(o_acc_data1), 32'(m_d1));
                check("acc_data2", 32'(o_acc_data2), 32'(m_d2));
            end else begin
                check("acc_sel_hold", 32'(o_acc_sel), 32'(2'b11));
            end
        end
    end

    // ---------------- directed stimulus
    task automatic check_reset_vals(input string tag);
        check({tag, "_acc_rst_n"}, 32'(o_acc_rst_n), 32'(0));
        check({tag, "_acc_sel"}, 32'(o_acc_sel), 32'(3));
        check({tag, "_acc_data"}, 32'({o_acc_data1, o_acc_data2}), 32'(0));
        check({tag, "_busy"}, 32'(o_busy), 32'(0));
        check({tag, "_done"}, 32'(o_done), 32'(0));
        check({tag, "_result"}, 32'(o_result), 32'(0));
        check({tag, "_carry"}, 32'(o_carry), 32'(0));
        check({tag, "_mismatch"}, 32'(o_mismatch), 32'(0));
    endtask

    // Issue a one-cycle start, then scramble the inputs to show they were latched.
    task automatic send(input logic [1:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [NW-1:0] n, input logic inj_v, output int t0);
        @(negedge clk);
        i_start = 1'b1;
        i_sel   = s;
        i_data1 = a;
        i_data2 = b;
        i_n_ops = n;
        inj     = inj_v;
        @(negedge clk);
        i_start = 1'b0;
        i_sel   = ~s;
        i_data1 = ~a;
        i_data2 = ~b;
        i_n_ops = ~n;
        t0      = edge_cnt;
    endtask

    task automatic wait_done(input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (o_done) begin
                lat = edge_cnt - t0 + 1;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) check("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] s, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [NW-1:0] n, input logic inj_v,
                           input int exp_lat, input int exp_res, input int exp_cy);
        int t0, lat;
        send(s, a, b, n, inj_v, t0);
        wait_done(t0, lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, 32'(o_result), 32'(exp_res));
        check({tag, "_carry"}, 32'(o_carry), 32'(exp_cy));
        check({tag, "_busy_in_done"}, 32'(o_busy), 32'(1));
        @(negedge clk);
        inj = 1'b0;
        check({tag, "_busy_after"}, 32'(o_busy), 32'(0));
    endtask

    initial begin
        int t0, lat, n_done;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_sel   = 2'b00;
        i_data1 = '0;
        i_data2 = '0;
        i_n_ops = '0;
        inj     = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        i_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_cmd("t1", 2'b00, 3'd1, 3'd0, 4'd4, 1'b0, 7, 4, 0);
        run_cmd("t2a", 2'b10, 3'd3, 3'd4, 4'd9, 1'b0, 12, 63, 0);
        run_cmd("t2b", 2'b10, 3'd3, 3'd4, 4'd10, 1'b0, 13, 6, 1);
        run_cmd("t3", 2'b01, 3'd0, 3'd5, 4'd0, 1'b0, 3, 0, 0);
        run_cmd("hold", 2'b11, 3'd7, 3'd7, 4'd5, 1'b0, 8, 0, 0);
        run_cmd("max", 2'b10, 3'd7, 3'd7, 4'd15, 1'b0, 18, 18, 1);

        // Starts during RUN and in the DONE cycle are both dropped.
        send(2'b00, 3'd2, 3'd0, 4'd5, 1'b0, t0);
        @(negedge clk);
        i_start = 1'b1;
        i_sel   = 2'b10;
        i_data1 = 3'd7;
        i_data2 = 3'd7;
        i_n_ops = 4'd15;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(t0, lat);
        check("t4_latency", 32'(lat), 32'(8));
        check("t4_result", 32'(o_result), 32'(10));
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("t4_busy_after_done_start", 32'(o_busy), 32'(0));
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_done) n_done++;
        end
        check("t4_no_extra_done", 32'(n_done), 32'(0));
        run_cmd("t4_next", 2'b01, 3'd0, 3'd6, 4'd3, 1'b0, 6, 18, 0);

        // Asynchronous reset mid-RUN.
        send(2'b00, 3'd1, 3'd0, 4'd8, 1'b0, t0);
        repeat (3) @(negedge clk);
        check("t5_busy_before", 32'(o_busy), 32'(1));
        #2 i_rst_n = 1'b0;
        #1 check_reset_vals("t5");
        @(negedge clk);
        i_rst_n = 1'b1;
        n_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (o_done) n_done++;
        end
        check("t5_no_done", 32'(n_done), 32'(0));

        // Stub reads back one too high: checker flags it only when compiled in.
        run_cmd("t6", 2'b00, 3'd2, 3'd0, 4'd3, 1'b1, 6, 7, 0);
        check("t6_mismatch_held", 32'(o_mismatch), 32'(CHK));
        send(2'b00, 3'd1, 3'd0, 4'd2, 1'b0, t0);
        check("t6_mismatch_cleared", 32'(o_mismatch), 32'(0));
        wait_done(t0, lat);
        check("t6_next_result", 32'(o_result), 32'(2));
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule
